// File: rtl/ex_div_unit.sv
// ex_div_unit: iterative radix-2 restoring divider for the EX stage (DIV/DIVU).
// One quotient bit per cycle, MSB first. The pipeline is stalled while the
// divide runs, and the result is held in END until EX drops start.
//
// state  | meaning
// -------+-------------------------------------------------------------
// FREE   | idle; operands latched when start=1 and annul=0
// BYZERO | divisor was zero; next cycle publish all-ones / dividend
// ON     | one restoring step per cycle, WIDTH cycles total
// END    | ready=1, result held while start stays high
module ex_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     opdata1,
    input  logic [WIDTH-1:0]     opdata2,
    input  logic                 annul,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready,
    output logic                 stallreq_ex
);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]      dvd_q, dvd_d;      // shifting |dividend|
    logic [WIDTH-1:0]      dvs_q, dvs_d;      // |divisor|
    logic [WIDTH-1:0]      rem_q, rem_d;      // partial remainder (always < divisor)
    logic [WIDTH-1:0]      quot_q, quot_d;
    logic [WIDTH-1:0]      op1_q, op1_d;      // raw dividend, needed for divide-by-zero
    logic                  qneg_q, qneg_d;    // negate quotient at the end
    logic                  rneg_q, rneg_d;    // negate remainder at the end
    logic [2*WIDTH-1:0]    result_q, result_d;

    logic [WIDTH-1:0]      abs1, abs2;
    logic [WIDTH:0]        rem_shift, trial;
    logic                  q_bit;
    logic [WIDTH-1:0]      rem_next, quot_next, quot_fix, rem_fix;
    logic                  last_step;

    // Magnitudes only matter for signed divides; the most negative value maps
    // to itself, which is still correct when read as unsigned.
    assign abs1 = (signed_div && opdata1[WIDTH-1]) ? (~opdata1 + WIDTH'(1)) : opdata1;
    assign abs2 = (signed_div && opdata2[WIDTH-1]) ? (~opdata2 + WIDTH'(1)) : opdata2;

    // One restoring step: the WIDTH+1 bit trial goes negative exactly when the
    // shifted remainder is below the divisor, so its MSB is the inverted quotient bit.
    assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
    assign trial     = rem_shift - {1'b0, dvs_q};
    assign q_bit     = ~trial[WIDTH];
    assign rem_next  = q_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    assign quot_next = {quot_q[WIDTH-2:0], q_bit};
    assign quot_fix  = qneg_q ? (~quot_next + WIDTH'(1)) : quot_next;
    assign rem_fix   = rneg_q ? (~rem_next + WIDTH'(1)) : rem_next;
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

    // Next-state and datapath update; annul overrides everything below reset.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        op1_d    = op1_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;

        case (state_q)
            S_FREE: begin
                if (start && !annul) begin
                    dvd_d   = abs1;
                    dvs_d   = abs2;
                    op1_d   = opdata1;
                    qneg_d  = signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                    rneg_d  = signed_div & opdata1[WIDTH-1];
                    rem_d   = '0;
                    quot_d  = '0;
                    cnt_d   = '0;
                    state_d = (opdata2 == '0) ? S_BYZERO : S_ON;
                end
            end
            S_BYZERO: begin
                state_d  = S_END;
                result_d = {op1_q, {WIDTH{1'b1}}};
            end
            S_ON: begin
                rem_d  = rem_next;
                quot_d = quot_next;
                dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_step) begin
                    state_d  = S_END;
                    result_d = {rem_fix, quot_fix};
                end
            end
            S_END: begin
                if (!start) begin
                    state_d  = S_FREE;
                    result_d = '0;
                end
            end
            default: begin
                state_d  = S_FREE;
                result_d = '0;
            end
        endcase

        if (annul) begin
            state_d  = S_FREE;
            result_d = '0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FREE;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            op1_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            op1_q    <= op1_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    assign result      = result_q;
    assign ready       = (state_q == S_END);
    assign stallreq_ex = start & ~ready & ~annul;

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed bench for ex_div_unit: latency, stall, signed fix-up, divide by
// zero, overflow, annul, result hold and reset.
module tb_ex_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        stallreq_ex;

    int checks;
    int errors;
    int lat;
    int sbad;
    int hold_bad;

    ex_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_div  (signed_div),
        .opdata1     (opdata1),
        .opdata2     (opdata2),
        .annul       (annul),
        .result      (result),
        .ready       (ready),
        .stallreq_ex (stallreq_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Raise start with the given operands and wait (bounded) for ready.
    // lat = number of clock edges until ready, 0 on timeout. sbad counts
    // cycles before ready where stallreq_ex was not asserted. Operands are
    // scrambled mid-run to show they are not resampled.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                          output int lat_o, output int sbad_o);
        opdata1    = a;
        opdata2    = b;
        signed_div = sg;
        start      = 1'b1;
        lat_o      = 0;
        sbad_o     = 0;
        #1;
        if (stallreq_ex !== 1'b1) sbad_o++;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                lat_o = n;
                break;
            end
            if (stallreq_ex !== 1'b1) sbad_o++;
            if (n == 3) begin
                opdata1    = ~a;
                opdata2    = b + 32'd1;
                signed_div = ~sg;
            end
        end
    endtask

    task automatic release_start();
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        start      = 1'b0;
        signed_div = 1'b0;
        opdata1    = 32'h0;
        opdata2    = 32'h0;
        annul      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", {63'd0, ready}, 64'd0);
        chk("reset_result", result, 64'd0);
        chk("reset_stall", {63'd0, stallreq_ex}, 64'd0);

        // DIVU 100/7, then hold the result for 5 cycles
        do_div(32'd100, 32'd7, 1'b0, lat, sbad);
        chk("divu_lat", lat, 33);
        chk("divu_stall_before_ready", sbad, 0);
        chk("divu_stall_at_ready", {63'd0, stallreq_ex}, 64'd0);
        chk("divu_result", result, {32'd2, 32'd14});
        hold_bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (result !== {32'd2, 32'd14} || ready !== 1'b1) hold_bad++;
        end
        chk("hold_result", hold_bad, 0);
        release_start();
        chk("release_ready", {63'd0, ready}, 64'd0);
        chk("release_result", result, 64'd0);

        // Signed divides
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1, lat, sbad);
        chk("div_neg7_by_2", result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        release_start();
        do_div(32'd7, 32'hFFFF_FFFE, 1'b1, lat, sbad);
        chk("div_7_by_neg2", result, {32'h0000_0001, 32'hFFFF_FFFD});
        release_start();
        do_div(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, lat, sbad);
        chk("div_neg7_by_neg2", result, {32'hFFFF_FFFF, 32'h0000_0003});
        release_start();

        // Unsigned corner cases: large dividend, divisor larger than dividend
        do_div(32'hFFFF_FFFF, 32'd1, 1'b0, lat, sbad);
        chk("divu_max_by_1", result, {32'h0, 32'hFFFF_FFFF});
        release_start();
        do_div(32'd5, 32'd10, 1'b0, lat, sbad);
        chk("divu_5_by_10", result, {32'd5, 32'd0});
        release_start();

        // Divide by zero
        do_div(32'h1234_5678, 32'h0, 1'b0, lat, sbad);
        chk("div0_lat", lat, 2);
        chk("div0_result", result, {32'h1234_5678, 32'hFFFF_FFFF});
        release_start();

        // Signed overflow wraps
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, sbad);
        chk("ovf_lat", lat, 33);
        chk("ovf_result", result, {32'h0, 32'h8000_0000});
        release_start();

        // Annul at cycle 10 of ON
        opdata1    = 32'd100;
        opdata2    = 32'd7;
        signed_div = 1'b0;
        start      = 1'b1;
        for (int i = 0; i < 10; i++) @(negedge clk);
        annul = 1'b1;
        #1;
        chk("annul_stall_same_cycle", {63'd0, stallreq_ex}, 64'd0);
        @(negedge clk);
        annul = 1'b0;
        start = 1'b0;
        #1;
        chk("annul_ready", {63'd0, ready}, 64'd0);
        chk("annul_stall", {63'd0, stallreq_ex}, 64'd0);
        chk("annul_result", result, 64'd0);
        @(negedge clk);
        do_div(32'd9, 32'd3, 1'b0, lat, sbad);
        chk("after_annul_lat", lat, 33);
        chk("after_annul_result", result, {32'd0, 32'd3});
        release_start();

        // Reset mid-ON, then a full divide still takes 33 cycles
        opdata1 = 32'd100;
        opdata2 = 32'd7;
        start   = 1'b1;
        for (int i = 0; i < 5; i++) @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk("rst_mid_on_ready", {63'd0, ready}, 64'd0);
        chk("rst_mid_on_result", result, 64'd0);
        chk("rst_mid_on_stall", {63'd0, stallreq_ex}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        do_div(32'd9, 32'd3, 1'b0, lat, sbad);
        chk("after_rst_lat", lat, 33);

        // Reset while holding a result in END clears it
        rst = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        #1;
        chk("rst_in_end_ready", {63'd0, ready}, 64'd0);
        chk("rst_in_end_result", result, 64'd0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
